// File: rtl/shared_bv_gather.sv
// Boolean-shared bit-vector gather: joins NUM_PARTS narrow parts into one
// wide registered word per share, with a valid/ready handshake on each side.
module shared_bv_gather #(
   parameter int NUM_SHARES = 2,
   parameter int PART_WIDTH = 15,
   parameter int NUM_PARTS  = 2,
   parameter int HIGH_FIRST = 0,
   localparam int BIT_WIDTH = NUM_PARTS * PART_WIDTH,
   localparam int CW        = $clog2(NUM_PARTS + 1)
) (
   input  logic                                   in_clock,
   input  logic                                   in_reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [NUM_SHARES-1:0][PART_WIDTH-1:0]  in_part,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]   out_b,
   output logic [CW-1:0]                          out_count
);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t                                 r_state;
   state_t                                 w_state_nxt;
   logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]   r_data;
   logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]   w_data_nxt;
   logic [CW-1:0]                          r_count;
   logic [CW-1:0]                          w_count_nxt;
   logic [CW-1:0]                          w_k;
   int                                     w_slot;
   logic                                   w_part_xfer;
   logic                                   w_word_xfer;

   initial begin
      assert (NUM_PARTS >= 2 && NUM_PARTS <= 16);
   end

   // Ready depends only on state and out_ready, never on in_valid.
   assign in_ready    = (r_state == COLLECT) | out_ready;
   assign out_valid   = (r_state == FULL);
   assign w_part_xfer = in_valid & in_ready;
   assign w_word_xfer = out_valid & out_ready;
   assign out_b       = r_data;
   assign out_count   = r_count;

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_count_nxt = r_count;
      w_k         = r_count;
      w_slot      = 0;

      // A consumed word is wiped so its shares are never shown again.
      if (w_word_xfer) begin
         w_state_nxt = COLLECT;
         w_data_nxt  = '0;
         w_count_nxt = '0;
         w_k         = '0;
      end

      if (HIGH_FIRST != 0)
         w_slot = NUM_PARTS - 1 - int'(w_k);
      else
         w_slot = int'(w_k);

      if (w_part_xfer) begin
         for (int s = 0; s < NUM_SHARES; s++) begin
            w_data_nxt[s][w_slot*PART_WIDTH +: PART_WIDTH] = in_part[s];
         end
         w_count_nxt = w_k + CW'(1);
         if (w_k == CW'(NUM_PARTS - 1))
            w_state_nxt = FULL;
      end
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         r_state <= COLLECT;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_count <= w_count_nxt;
      end
   end

endmodule

// File: tb/tb_shared_bv_gather.sv
// Randomized scoreboard bench for shared_bv_gather, run on a low-first and a
// high-first instance driven by the same stimulus.
module tb_shared_bv_gather;

   localparam int NS = 2;
   localparam int PW = 4;
   localparam int NP = 3;
   localparam int BW = NP * PW;

   logic                    clk;
   logic                    in_reset;
   logic                    in_valid;
   logic                    out_ready;
   logic [NS-1:0][PW-1:0]   in_part;

   logic                    rdy0, rdy1, ov0, ov1;
   logic [NS-1:0][BW-1:0]   ob0, ob1;
   logic [1:0]              cnt0, cnt1;

   int total = 0;
   int bad   = 0;
   int words0 = 0;

   logic [NS-1:0][BW-1:0]   q0[$];
   logic [NS-1:0][BW-1:0]   q1[$];

   logic [NS-1:0][PW-1:0]   parts[NP];
   int                      mk = 0;

   shared_bv_gather #(
      .NUM_SHARES(NS), .PART_WIDTH(PW), .NUM_PARTS(NP), .HIGH_FIRST(0)
   ) dut0 (
      .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
      .in_ready(rdy0), .in_part(in_part), .out_valid(ov0),
      .out_ready(out_ready), .out_b(ob0), .out_count(cnt0)
   );

   shared_bv_gather #(
      .NUM_SHARES(NS), .PART_WIDTH(PW), .NUM_PARTS(NP), .HIGH_FIRST(1)
   ) dut1 (
      .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
      .in_ready(rdy1), .in_part(in_part), .out_valid(ov1),
      .out_ready(out_ready), .out_b(ob1), .out_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Word formed by the first n held parts, placed by arithmetic on position.
   function automatic logic [NS-1:0][BW-1:0] expb(input int hf, input int n);
      logic [NS-1:0][BW-1:0] r;
      int pos;
      r = '0;
      for (int j = 0; j < n; j++) begin
         pos = (hf != 0) ? (NP - 1 - j) : j;
         for (int s = 0; s < NS; s++)
            r[s] = r[s] | (BW'(parts[j][s]) << (PW * pos));
      end
      return r;
   endfunction

   // Reference model: checks state every cycle, then advances on the inputs
   // that the coming rising edge will sample.
   always @(negedge clk) begin
      logic full, mrdy, wx, px;
      logic [NS-1:0][BW-1:0] e0, e1;
      full = (mk == NP);
      mrdy = !full || out_ready;
      e0 = expb(0, mk);
      e1 = expb(1, mk);
      chk("out_valid0", 32'(ov0), 32'(full));
      chk("out_valid1", 32'(ov1), 32'(full));
      chk("in_ready0", 32'(rdy0), 32'(mrdy));
      chk("in_ready1", 32'(rdy1), 32'(mrdy));
      chk("out_count0", 32'(cnt0), 32'(mk));
      chk("out_count1", 32'(cnt1), 32'(mk));
      chk("out_b0", 32'(ob0), 32'(e0));
      chk("out_b1", 32'(ob1), 32'(e1));
      if (!in_reset) begin
         mk = 0;
         q0.delete();
         q1.delete();
      end else begin
         wx = full && out_ready;
         px = in_valid && mrdy;
         if (wx) mk = 0;
         if (px) begin
            parts[mk] = in_part;
            mk++;
            if (mk == NP) begin
               q0.push_back(expb(0, NP));
               q1.push_back(expb(1, NP));
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NS-1:0][BW-1:0] w;
      if (in_reset && out_ready && ov0) begin
         if (q0.size() == 0) chk("word0_unexpected", 32'(1), 32'(0));
         else begin
            w = q0.pop_front();
            chk("word0", 32'(ob0), 32'(w));
         end
         words0++;
      end
      if (in_reset && out_ready && ov1) begin
         if (q1.size() == 0) chk("word1_unexpected", 32'(1), 32'(0));
         else begin
            w = q1.pop_front();
            chk("word1", 32'(ob1), 32'(w));
         end
      end
   end

   task automatic drive(input logic v, input logic [PW-1:0] s1,
                        input logic [PW-1:0] s0, input logic r);
      in_valid   = v;
      in_part[1] = s1;
      in_part[0] = s0;
      out_ready  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_reset = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0);
      drive(1'b0, 4'h0, 4'h0, 1'b0);
      in_reset = 1'b1;
   endtask

   initial begin
      int wb;
      in_reset  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_part   = '0;
      do_reset();
      chk("rst_count", 32'(cnt0), 32'(0));
      chk("rst_valid", 32'(ov0), 32'(0));
      chk("rst_ready", 32'(rdy0), 32'(1));
      chk("rst_b", 32'(ob0), 32'(0));

      drive(1'b1, 4'h1, 4'hA, 1'b0);
      drive(1'b1, 4'h2, 4'hB, 1'b0);
      drive(1'b1, 4'h3, 4'hC, 1'b0);
      chk("join_valid", 32'(ov0), 32'(1));
      chk("join_b0_s0", 32'(ob0[0]), 32'h0CBA);
      chk("join_b0_s1", 32'(ob0[1]), 32'h0321);
      chk("join_count", 32'(cnt0), 32'(3));
      chk("join_ready", 32'(rdy0), 32'(0));
      chk("hf_b1_s0", 32'(ob1[0]), 32'h0ABC);
      chk("hf_b1_s1", 32'(ob1[1]), 32'h0123);

      for (int i = 0; i < 5; i++) drive(1'b0, 4'h0, 4'h0, 1'b0);
      chk("bp_b0_s0", 32'(ob0[0]), 32'h0CBA);
      chk("bp_ready", 32'(rdy0), 32'(0));
      drive(1'b1, 4'h7, 4'h5, 1'b1);
      chk("stream_valid", 32'(ov0), 32'(0));
      chk("stream_count", 32'(cnt0), 32'(1));
      chk("stream_b0_s0", 32'(ob0[0]), 32'h0005);
      chk("stream_b0_s1", 32'(ob0[1]), 32'h0007);
      chk("stream_b1_s0", 32'(ob1[0]), 32'h0500);
      chk("stream_b1_s1", 32'(ob1[1]), 32'h0700);

      do_reset();
      wb = words0;
      for (int i = 0; i < 9; i++)
         drive(1'b1, 4'($urandom), 4'($urandom), 1'b1);
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      chk("tput_words", 32'(words0 - wb), 32'(3));

      drive(1'b1, 4'h8, 4'h9, 1'b0);
      drive(1'b1, 4'h8, 4'h9, 1'b0);
      in_reset = 1'b0;
      drive(1'b1, 4'h8, 4'h9, 1'b0);
      in_reset = 1'b1;
      chk("midrst_count", 32'(cnt0), 32'(0));
      chk("midrst_b", 32'(ob0), 32'(0));
      chk("midrst_valid", 32'(ov0), 32'(0));
      drive(1'b1, 4'h4, 4'hD, 1'b0);
      drive(1'b1, 4'h5, 4'hE, 1'b0);
      drive(1'b1, 4'h6, 4'hF, 1'b0);
      chk("fresh_b0_s0", 32'(ob0[0]), 32'h0FED);
      chk("fresh_b0_s1", 32'(ob0[1]), 32'h0654);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'($urandom), 4'hF, 4'h0, 1'($urandom));
         chk("iso_s0", 32'(ob0[0]), 32'h0);
         chk("iso_s1_hf", 32'(ob1[0]), 32'h0);
      end

      for (int i = 0; i < 400; i++) begin
         in_reset = ($urandom_range(0, 40) != 0);
         drive(1'($urandom), 4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) != 0));
      end
      in_reset = 1'b1;
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      drive(1'b0, 4'h0, 4'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
